// File: rtl/uart_port.sv
// uart_port: 8N1 UART with byte transmitter and buffered receiver.
// Define UART_PORT_RX_FIFO_EN for a 4-entry RX FIFO (default: 1 entry).
module uart_port #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic       uart0_wr,
  input  logic [7:0] uart_w,
  input  logic       uart0_rd,
  output logic [7:0] uart0_data,
  output logic       uart0_valid,
  output logic       uart0_busy,
  output logic       uart0_ovf,
  output logic       uart_txd,
  input  logic       uart_rxd
);

  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_PORT_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DEPTH - 1);
  localparam logic [2:0] FULL = 3'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // ---------------- transmitter ----------------
  state_t      tx_st, tx_nx;
  logic [15:0] tx_cnt, tx_cnt_n;
  logic [2:0]  tx_bit, tx_bit_n;
  logic [7:0]  tx_sh, tx_sh_n;
  logic        tx_wrap;

  assign tx_wrap = (tx_cnt == LAST);

  // TX state register
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      tx_st  <= S_IDLE;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh  <= '0;
    end else begin
      tx_st  <= tx_nx;
      tx_cnt <= tx_cnt_n;
      tx_bit <= tx_bit_n;
      tx_sh  <= tx_sh_n;
    end
  end

  // TX next state: writes only accepted while idle
  always_comb begin
    tx_nx    = tx_st;
    tx_cnt_n = tx_cnt;
    tx_bit_n = tx_bit;
    tx_sh_n  = tx_sh;
    unique case (tx_st)
      S_IDLE: begin
        if (uart0_wr) begin
          tx_nx    = S_START;
          tx_cnt_n = '0;
          tx_sh_n  = uart_w;
        end
      end
      S_START: begin
        if (tx_wrap) begin
          tx_nx    = S_DATA;
          tx_cnt_n = '0;
          tx_bit_n = '0;
        end else begin
          tx_cnt_n = tx_cnt + 16'd1;
        end
      end
      S_DATA: begin
        if (tx_wrap) begin
          tx_cnt_n = '0;
          tx_sh_n  = {1'b0, tx_sh[7:1]};
          if (tx_bit == 3'd7) tx_nx = S_STOP;
          else tx_bit_n = tx_bit + 3'd1;
        end else begin
          tx_cnt_n = tx_cnt + 16'd1;
        end
      end
      S_STOP: begin
        if (tx_wrap) begin
          tx_nx    = S_IDLE;
          tx_cnt_n = '0;
        end else begin
          tx_cnt_n = tx_cnt + 16'd1;
        end
      end
      default: tx_nx = S_IDLE;
    endcase
  end

  // TX line and busy decode from registered state
  always_comb begin
    uart_txd   = 1'b1;
    uart0_busy = (tx_st != S_IDLE);
    unique case (tx_st)
      S_START: uart_txd = 1'b0;
      S_DATA:  uart_txd = tx_sh[0];
      default: uart_txd = 1'b1;
    endcase
  end

  // ---------------- receiver ----------------
  logic [1:0] rx_sync;
  logic       rx_s, rx_prev, rx_fall;

  // two-flop synchronizer plus edge history
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], uart_rxd};
      rx_prev <= rx_sync[1];
    end
  end

  assign rx_s    = rx_sync[1];
  assign rx_fall = rx_prev & ~rx_s;

  state_t      rx_st, rx_nx;
  logic [15:0] rx_cnt, rx_cnt_n;
  logic [2:0]  rx_bit, rx_bit_n;
  logic [7:0]  rx_sh, rx_sh_n;
  logic        rx_wrap, push;

  assign rx_wrap = (rx_cnt == LAST);

  // RX state register
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_st  <= S_IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh  <= '0;
    end else begin
      rx_st  <= rx_nx;
      rx_cnt <= rx_cnt_n;
      rx_bit <= rx_bit_n;
      rx_sh  <= rx_sh_n;
    end
  end

  // RX next state: mid-bit sampling, glitch and framing rejection
  always_comb begin
    rx_nx    = rx_st;
    rx_cnt_n = rx_cnt;
    rx_bit_n = rx_bit;
    rx_sh_n  = rx_sh;
    push     = 1'b0;
    unique case (rx_st)
      S_IDLE: begin
        if (rx_fall) begin
          rx_nx    = S_START;
          rx_cnt_n = '0;
        end
      end
      S_START: begin
        if (rx_cnt == HALF) begin
          rx_cnt_n = '0;
          rx_bit_n = '0;
          rx_nx    = rx_s ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_n = rx_cnt + 16'd1;
        end
      end
      S_DATA: begin
        if (rx_wrap) begin
          rx_cnt_n = '0;
          rx_sh_n  = {rx_s, rx_sh[7:1]};
          if (rx_bit == 3'd7) rx_nx = S_STOP;
          else rx_bit_n = rx_bit + 3'd1;
        end else begin
          rx_cnt_n = rx_cnt + 16'd1;
        end
      end
      S_STOP: begin
        if (rx_wrap) begin
          rx_nx    = S_IDLE;
          rx_cnt_n = '0;
          push     = rx_s;
        end else begin
          rx_cnt_n = rx_cnt + 16'd1;
        end
      end
      default: rx_nx = S_IDLE;
    endcase
  end

  // ---------------- receive buffer ----------------
  logic [7:0]    mem [0:(1<<PW)-1];
  logic [PW-1:0] wp, rp;
  logic [2:0]    cnt;
  logic          pop, full, acc, drop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PMAX) ? '0 : p + PW'(1);
  endfunction

  assign pop  = uart0_rd & (cnt != 3'd0);
  assign full = (cnt == FULL);
  assign acc  = push & (~full | pop);
  assign drop = push & full & ~pop;

  // buffer storage, pointers and sticky overrun
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      for (int i = 0; i < (1 << PW); i++) mem[i] <= '0;
      wp        <= '0;
      rp        <= '0;
      cnt       <= '0;
      uart0_ovf <= 1'b0;
    end else begin
      if (acc) begin
        mem[wp] <= rx_sh;
        wp      <= nxt(wp);
      end
      if (pop) rp <= nxt(rp);
      cnt       <= cnt + 3'(acc) - 3'(pop);
      uart0_ovf <= uart0_ovf | drop;
    end
  end

  assign uart0_data  = mem[rp];
  assign uart0_valid = (cnt != 3'd0);

endmodule
